// File: rtl/bp_profiler_snapshot_streamer.sv
// Snapshots the profiler counter array into shadow registers and streams it
// out as a sequence-numbered header followed by els_p data words.

module bp_pss_shadow_word #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               cap_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);
  logic [width_p-1:0] word_q;

  // Shadow contents are only meaningful after a capture, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (cap_i) word_q <= d_i;
  end

  assign q_o = word_q;
endmodule

module bp_profiler_snapshot_streamer #(
  parameter int width_p        = 32,
  parameter int els_p          = 65,
  parameter int period_width_p = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       freeze_i,
  input  logic                       en_i,
  input  logic [period_width_p-1:0]  sample_period_i,
  input  logic                       trigger_i,
  input  logic [els_p*width_p-1:0]   counters_i,
  output logic [width_p-1:0]         data_o,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic                       last_o,
  output logic                       busy_o,
  output logic [width_p-1:0]         overrun_o
);
  localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [idx_w_lp-1:0]       last_idx_lp = idx_w_lp'(els_p - 1);
  localparam logic [idx_w_lp-1:0]       idx_one_lp  = idx_w_lp'(1);
  localparam logic [period_width_p-1:0] tmr_one_lp  = period_width_p'(1);
  localparam logic [width_p-1:0]        w_one_lp    = width_p'(1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

  state_e                        state_q, state_d;
  logic [period_width_p-1:0]     timer_q, timer_d;
  logic [width_p-1:0]            seq_q, seq_d;
  logic [width_p-1:0]            data_q, data_d;
  logic [width_p-1:0]            ovr_q, ovr_d;
  logic [idx_w_lp-1:0]           idx_q, idx_d, idx_nxt;
  logic                          v_q, v_d, last_q, last_d;
  logic [els_p-1:0][width_p-1:0] shadow_q;
  logic                          tmr_run, tick, req, hs, last_hs, busy, capture, drop;

  assign tmr_run = en_i && (sample_period_i != '0);
  // ">=" so a period lowered below the running count still fires promptly.
  assign tick    = tmr_run && (timer_q >= (sample_period_i - tmr_one_lp));
  assign req     = trigger_i | tick;
  assign hs      = v_q & ready_i;
  assign last_hs = hs & last_q;
  assign busy    = (state_q != IDLE);
  assign capture = req && !freeze_i && ((state_q == IDLE) || ((state_q == DATA) && last_hs));
  assign drop    = req && !freeze_i && busy && !capture;
  assign idx_nxt = idx_q + idx_one_lp;

  for (genvar g = 0; g < els_p; g++) begin : g_shadow
    bp_pss_shadow_word #(.width_p(width_p)) u_word (
      .clk_i (clk_i),
      .cap_i (capture),
      .d_i   (counters_i[g*width_p +: width_p]),
      .q_o   (shadow_q[g])
    );
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    data_d  = data_q;
    v_d     = v_q;
    last_d  = last_q;
    ovr_d   = ovr_q;

    if (tmr_run) timer_d = tick ? '0 : timer_q + tmr_one_lp;

    unique case (state_q)
      HDR: begin
        if (hs) begin
          seq_d   = seq_q + w_one_lp;
          idx_d   = '0;
          state_d = DATA;
          data_d  = shadow_q[0];
          last_d  = (els_p == 1);
        end
      end
      DATA: begin
        if (hs) begin
          if (last_q) begin
            state_d = IDLE;
            v_d     = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
          end else begin
            idx_d  = idx_nxt;
            data_d = shadow_q[idx_nxt];
            last_d = (idx_nxt == last_idx_lp);
          end
        end
      end
      default: ;
    endcase

    // A capture on the final beat overrides the return to IDLE: no bubble.
    if (capture) begin
      state_d = HDR;
      v_d     = 1'b1;
      last_d  = 1'b0;
      data_d  = seq_q;
    end else if (drop && (ovr_q != '1)) begin
      ovr_d = ovr_q + w_one_lp;
    end

    if (freeze_i) begin
      state_d = IDLE;
      timer_d = '0;
      seq_d   = '0;
      idx_d   = '0;
      data_d  = '0;
      v_d     = 1'b0;
      last_d  = 1'b0;
      ovr_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      seq_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      v_q     <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      v_q     <= v_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign v_o       = v_q;
  assign last_o    = last_q;
  assign busy_o    = busy;
  assign overrun_o = ovr_q;
endmodule

// File: tb/tb_bp_profiler_snapshot_streamer.sv
// Randomized bench: a beat-count reference model queues expected stream words,
// a negedge monitor pops and compares them against the DUT.

module tb_bp_profiler_snapshot_streamer;
  localparam int W  = 32;
  localparam int N  = 65;
  localparam int PW = 32;

  logic           clk_i = 1'b0;
  logic           reset_n_i = 1'b0;
  logic           freeze_i = 1'b0;
  logic           en_i = 1'b0;
  logic           trigger_i = 1'b0;
  logic           ready_i = 1'b0;
  logic [PW-1:0]  sample_period_i = '0;
  logic [N*W-1:0] counters_i = '0;
  logic [W-1:0]   data_o, overrun_o;
  logic           v_o, last_o, busy_o;

  always #5 clk_i = ~clk_i;

  bp_profiler_snapshot_streamer #(.width_p(W), .els_p(N), .period_width_p(PW)) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .freeze_i        (freeze_i),
    .en_i            (en_i),
    .sample_period_i (sample_period_i),
    .trigger_i       (trigger_i),
    .counters_i      (counters_i),
    .data_o          (data_o),
    .v_o             (v_o),
    .ready_i         (ready_i),
    .last_o          (last_o),
    .busy_o          (busy_o),
    .overrun_o       (overrun_o)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        exp_b;
  int           n_chk = 0;
  int           n_fail = 0;
  int           rem = 0;       // beats still owed by the snapshot in flight
  logic [W-1:0] m_seq = '0;
  logic [W-1:0] m_ovr = '0;
  longint       m_tmr = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    rem = 0; m_seq = '0; m_ovr = '0; m_tmr = 0;
    exp_q.delete();
  endtask

  // Decides what happens at the coming clock edge from the inputs now applied.
  task automatic model_step();
    bit tick, req, hs, lhs, idle;
    if (freeze_i) begin
      model_reset();
      return;
    end
    tick = en_i && (sample_period_i != 0) && (m_tmr >= longint'(sample_period_i) - 1);
    if (en_i && (sample_period_i != 0)) m_tmr = tick ? 0 : m_tmr + 1;
    req  = trigger_i || tick;
    idle = (rem == 0);
    hs   = !idle && ready_i;
    lhs  = hs && (rem == 1);
    if (hs) rem--;
    if (req) begin
      if (idle || lhs) begin
        exp_q.push_back('{m_seq, 1'b0});
        for (int k = 0; k < N; k++) exp_q.push_back('{counters_i[k*W +: W], k == N-1});
        m_seq++;
        rem = N + 1;
      end else if (m_ovr != '1) begin
        m_ovr++;
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      model_reset();
    end else begin
      chk("busy_o", W'(busy_o), W'(rem != 0));
      chk("v_o", W'(v_o), W'(rem != 0));
      chk("overrun_o", overrun_o, m_ovr);
      if (!freeze_i && v_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL stream: unexpected beat 0x%0h with nothing expected", data_o);
        end else begin
          exp_b = exp_q.pop_front();
          chk("data_o", data_o, exp_b.d);
          chk("last_o", W'(last_o), W'(exp_b.l));
        end
      end
      model_step();
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((busy_o || exp_q.size() != 0) && t < 1000) begin
      step();
      t++;
    end
    n_chk++;
    if (busy_o || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: stream not drained, busy_o=%0b pending=%0d", name, busy_o, exp_q.size());
    end
  endtask

  task automatic set_counters(input logic [W-1:0] base, input bit rnd);
    for (int k = 0; k < N; k++) counters_i[k*W +: W] = rnd ? W'($urandom) : base + W'(k);
  endtask

  task automatic pulse_trigger();
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ov0;
    int           t;

    repeat (3) step();
    chk("rst_v", W'(v_o), '0);
    chk("rst_last", W'(last_o), '0);
    chk("rst_busy", W'(busy_o), '0);
    chk("rst_data", data_o, '0);
    chk("rst_ovr", overrun_o, '0);
    reset_n_i = 1'b1;
    step();

    // Single manual snapshot, then a repeat with header 1.
    set_counters(W'(32'h1000), 1'b0);
    ready_i = 1'b1;
    pulse_trigger();
    chk("hdr_latency", W'(v_o), W'(1));
    chk("hdr0", data_o, W'(0));
    wait_idle("single");
    pulse_trigger();
    chk("hdr1", data_o, W'(1));
    wait_idle("repeat");

    // Periodic sampling with a stalling consumer and moving counters.
    sample_period_i = 200;
    en_i = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      ready_i = ~ready_i;
      set_counters('0, 1'b1);
      step();
    end
    chk("ovr_periodic", overrun_o, '0);

    // Overrun: short periods force drops while busy.
    sample_period_i = 10;
    ready_i = 1'b1;
    repeat (300) step();
    chk("ovr_p10_seen", W'(overrun_o != 0), W'(1));
    sample_period_i = 1;
    for (int c = 0; c < 1000; c++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      if (c % 7 == 0) set_counters('0, 1'b1);
      step();
    end
    en_i = 1'b0;
    sample_period_i = 0;
    ready_i = 1'b1;
    wait_idle("period1");

    // Back-to-back: trigger exactly on the last-beat handshake.
    ov0 = overrun_o;
    set_counters(W'(32'h3000), 1'b0);
    pulse_trigger();
    t = 0;
    while (!(v_o && last_o && ready_i) && t < 200) begin
      step();
      t++;
    end
    n_chk++;
    if (t >= 200) begin
      n_fail++;
      $display("FAIL b2b_wait: last beat got %0d cycles, required under 200", t);
    end
    pulse_trigger();
    chk("b2b_v", W'(v_o), W'(1));
    chk("b2b_last", W'(last_o), '0);
    chk("b2b_ovr", overrun_o, ov0);
    wait_idle("b2b");

    // Freeze mid-stream, with a trigger in the same cycle that must be ignored.
    pulse_trigger();
    repeat (30) step();
    freeze_i = 1'b1;
    trigger_i = 1'b1;
    step();
    freeze_i = 1'b0;
    trigger_i = 1'b0;
    chk("frz_v", W'(v_o), '0);
    chk("frz_busy", W'(busy_o), '0);
    chk("frz_ovr", overrun_o, '0);
    set_counters(W'(32'h2000), 1'b0);
    pulse_trigger();
    chk("frz_hdr", data_o, '0);
    wait_idle("freeze");

    // Asynchronous reset between edges, mid-stream.
    pulse_trigger();
    repeat (20) step();
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst_v", W'(v_o), '0);
    chk("arst_busy", W'(busy_o), '0);
    chk("arst_last", W'(last_o), '0);
    step();
    step();
    #2 reset_n_i = 1'b1;
    step();
    set_counters('0, 1'b1);
    pulse_trigger();
    chk("arst_hdr", data_o, '0);
    wait_idle("reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
